// File: rtl/tdc_capture_decoder.sv
// tdc_capture_decoder: launches a delay-line pulse, double-syncs taps, bubble-corrects and encodes the code
module tdc_capture_decoder #(
  parameter int N = 64,
  parameter int REC_CYC = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          pulse_o,
  input  logic [N-1:0]  dl_i,
  output logic [CW-1:0] code_o,
  output logic          overflow_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o
);
  typedef enum logic [2:0] {IDLE, LAUNCH, SYNC, ENCODE, DONE, RECOVER} state_t;
  state_t state, nxt;
  logic [N-1:0] s1, s2, c;
  logic [N+1:0] ext;
  logic [CW-1:0] enc;
  logic [7:0] cnt;
  // majority-of-three bubble correction, then the lowest zero tap becomes the code
  always_comb begin
    ext = {1'b0, s2, 1'b1};
    c = '0;
    enc = CW'(N);
    for (int i = 0; i < N; i++)
      c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    for (int i = N - 1; i >= 0; i--)
      if (!c[i]) enc = CW'(i);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state logic; start is only honoured in IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_i ? LAUNCH : IDLE;
      LAUNCH:  nxt = SYNC;
      SYNC:    nxt = ENCODE;
      ENCODE:  nxt = DONE;
      DONE:    nxt = (valid_o && ready_i) ? RECOVER : DONE;
      RECOVER: nxt = (cnt == 8'd0) ? IDLE : RECOVER;
      default: nxt = IDLE;
    endcase
  end
  // registered outputs, synchroniser stages and recovery counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse_o <= 1'b0;
      busy_o <= 1'b0;
      valid_o <= 1'b0;
      overflow_o <= 1'b0;
      code_o <= '0;
      s1 <= '0;
      s2 <= '0;
      cnt <= 8'd0;
    end else begin
      pulse_o <= (nxt == LAUNCH);
      busy_o <= (nxt != IDLE);
      if (state == LAUNCH) s1 <= dl_i;
      if (state == SYNC) s2 <= s1;
      if (state == ENCODE) begin
        code_o <= enc;
        overflow_o <= &c;
        valid_o <= 1'b1;
      end
      if (state == DONE && valid_o && ready_i) begin
        valid_o <= 1'b0;
        cnt <= 8'(REC_CYC - 1);
      end
      if (state == RECOVER && cnt != 8'd0) cnt <= cnt - 8'd1;
    end
endmodule
